decode_regfile_fwd: RTL and testbench
=====================================

Name: decode_regfile_fwd

Overview:
Parametrised next-generation decode stage for the pipelined Y86-64 core. It decodes source and destination register IDs from icode, reads a resettable register file with two write ports, and resolves operands through an N-source priority forwarding network. It also keeps a per-register in-flight write scoreboard so hazard control can see pending writers. It sits between the D and E pipeline registers.

Parameters:
XLEN, 64, data width of registers and forwarded values
NREGS, 15, number of architectural registers (IDs 0..NREGS-1)
RIDX_W, 4, register ID width; the all-ones ID is RNONE
NFWD, 5, number of forwarding sources; index 0 has highest priority
SB_W, 2, width of each scoreboard counter

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_i  in  1  synchronous, active-high reset
D_icode_i  in  4  decode-stage icode
D_rA_i  in  RIDX_W  rA field
D_rB_i  in  RIDX_W  rB field
D_valP_i  in  XLEN  incremented PC
d_issue_i  in  1  the D instruction advances to E this cycle (not stalled, not bubbled)
fwd_dst_i  in  NFWD*RIDX_W  forwarding destination IDs; slice k = source k
fwd_val_i  in  NFWD*XLEN  forwarding values; slice k = source k
W_dstE_i  in  RIDX_W  writeback port E register ID
W_valE_i  in  XLEN  writeback port E data
W_dstM_i  in  RIDX_W  writeback port M register ID
W_valM_i  in  XLEN  writeback port M data
d_srcA_o  out  RIDX_W  decoded srcA
d_srcB_o  out  RIDX_W  decoded srcB
d_dstE_o  out  RIDX_W  decoded dstE
d_dstM_o  out  RIDX_W  decoded dstM
d_valA_o  out  XLEN  resolved operand A
d_valB_o  out  XLEN  resolved operand B
d_busy_o  out  NREGS  bit r is set when the scoreboard count for register r is non-zero

Behaviour:
- Decode (combinational):
  - srcA = rA for RRMOVQ, RMMOVQ, OPQ, PUSHQ; RSP for RET, POPQ; otherwise RNONE.
  - srcB = rB for RMMOVQ, OPQ, MRMOVQ; RSP for CALL, RET, PUSHQ, POPQ; otherwise RNONE.
  - dstE = rB for OPQ, RRMOVQ, IRMOVQ; RSP for PUSHQ, POPQ, CALL, RET; otherwise RNONE.
  - dstM = rA for MRMOVQ, POPQ; otherwise RNONE.
- valA:
  - CALL or JXX: valA = D_valP_i.
  - Otherwise: the lowest-index source k with fwd_dst[k] == srcA and srcA != RNONE.
  - If no source matches: the register file value.
  - srcA == RNONE: output 0. An RNONE destination never matches.
- valB: same rules without the valP case.
- Register file read is combinational. An ID of RNONE, or any ID >= NREGS, reads 0.
- Writes occur at posedge when the ID != RNONE and the ID < NREGS.
  - If W_dstE == W_dstM in the same cycle, valM wins.
- Reset (rst_i high at posedge): all registers are cleared to 0 and all scoreboard counters to 0.
  - d_busy_o reads 0 in the first cycle after reset. Decode and valA/valB outputs stay combinational.
  - Reset mid-operation discards any same-cycle writes and issues.
- Scoreboard, per register r, updated each posedge:
  - inc = d_issue_i and (d_dstE == r or d_dstM == r). Counts once even if both equal r.
  - dec = (W_dstE == r) or (W_dstM == r). Counts once.
  - inc and dec together: count unchanged.
  - Saturates at 2^SB_W - 1; never goes below 0. Decrementing at 0 is ignored.
- Latency: decode and operand paths are 0 cycles. A write is visible in the register file the cycle after the edge; during the write cycle, forwarding supplies the value.

Optional Feature:
DECODE_RF_WRITE_THROUGH_EN
- Defined: a register-file read whose ID matches W_dstM_i or W_dstE_i in the same cycle returns the write data (M before E), independent of the forwarding slices.
- Undefined: a register-file read returns pre-edge contents; same-cycle W values reach the operands only through fwd slices.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants: IHALT..IPOPQ, ICALL, IRET, IJXX, IOPQ, etc.
  - RRSP = 4, RNONE = 4'hF
  - a register-ID typedef
- One sub-module, y86_regfile: array, reset clear, two write ports, two read ports, and the write-through option.
- Decode, forwarding and scoreboard stay in the top module.

Test Plan:
- Reset, then read: rst_i for 1 cycle, then OPQ rA=1 rB=2 with no forwarding -> valA = 0, valB = 0, d_busy_o = 0.
- Write then read: W_dstE=3, valE=0x55 at edge 1 and 0x77 at edge 2 with W_dstM=3, valM=0x99 -> RRMOVQ rA=3 reads 0x99 (M wins).
- Forwarding priority: fwd_dst[0]=5 (0xAA) and fwd_dst[2]=5 (0xBB), OPQ rA=5 -> valA = 0xAA. With fwd_dst[0]=RNONE and srcA=RNONE -> valA = 0.
- CALL with valP=0x1234, RSP forwarded 0x100 -> valA = 0x1234, valB = 0x100, dstE = 4.
- Scoreboard: POPQ rA=7 issued -> busy bits 4 and 7 set. Writeback of 4 and 7 in the same cycle as a new issue of OPQ rB=7 -> busy[7] stays set with count 1, busy[4] clears. Three more issues to r1 -> count saturates at 3; four retires -> 0.
- Write-through: W_dstE=6, valE=0xC0DE, no fwd slices, RRMOVQ rA=6 -> 0xC0DE when the macro is defined, old value (0) when it is not.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, special register IDs and the
// register-ID type used by the decode stage and its register file.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RRSP  = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    typedef logic [3:0] reg_id_t;

endpackage

// File: rtl/y86_regfile.sv
// Resettable register file: two write ports (M beats E on the same ID) and
// two combinational read ports. IDs equal to all-ones or >= NREGS read 0.
// Build option DECODE_RF_WRITE_THROUGH_EN: a read matching a same-cycle
// write returns the write data (M before E) instead of the stored value.
module y86_regfile
    import y86_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int NREGS  = 15,
    parameter int RIDX_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [RIDX_W-1:0] rd_a_id,
    input  logic [RIDX_W-1:0] rd_b_id,
    output logic [XLEN-1:0]   rd_a_data,
    output logic [XLEN-1:0]   rd_b_data,
    input  logic [RIDX_W-1:0] wr_e_id,
    input  logic [XLEN-1:0]   wr_e_data,
    input  logic [RIDX_W-1:0] wr_m_id,
    input  logic [XLEN-1:0]   wr_m_data
);

    localparam logic [RIDX_W-1:0] ID_NONE = '1;

    logic [XLEN-1:0] regs_reg [NREGS];

    // One storage slot per register; port M takes precedence over port E.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
        localparam logic [RIDX_W-1:0] RID = RIDX_W'(gi);
        localparam bit SLOT_OK = (RID != ID_NONE);

        // Clear on reset, otherwise capture whichever write port targets this slot.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                regs_reg[gi] <= '0;
            end else if (SLOT_OK && wr_m_id == RID) begin
                regs_reg[gi] <= wr_m_data;
            end else if (SLOT_OK && wr_e_id == RID) begin
                regs_reg[gi] <= wr_e_data;
            end
        end
    end

    function automatic logic [XLEN-1:0] read_port(input logic [RIDX_W-1:0] id);
        logic            id_ok;
        logic [XLEN-1:0] data;
        id_ok = (id != ID_NONE) && (32'(id) < 32'(NREGS));
        data  = '0;
        if (id_ok) begin
            data = regs_reg[id];
`ifdef DECODE_RF_WRITE_THROUGH_EN
            if (id == wr_m_id) begin
                data = wr_m_data;
            end else if (id == wr_e_id) begin
                data = wr_e_data;
            end
`endif
        end
        return data;
    endfunction

    // Both read ports are purely combinational.
    always_comb begin
        rd_a_data = read_port(rd_a_id);
        rd_b_data = read_port(rd_b_id);
    end

endmodule

// File: rtl/decode_regfile_fwd.sv
// Y86-64 decode stage: register-ID decode, register file read, priority
// forwarding (source 0 highest) and a per-register in-flight write scoreboard.
// Build option DECODE_RF_WRITE_THROUGH_EN is handled inside y86_regfile.
module decode_regfile_fwd
    import y86_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int NREGS  = 15,
    parameter int RIDX_W = 4,
    parameter int NFWD   = 5,
    parameter int SB_W   = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [3:0]               D_icode_i,
    input  logic [RIDX_W-1:0]        D_rA_i,
    input  logic [RIDX_W-1:0]        D_rB_i,
    input  logic [XLEN-1:0]          D_valP_i,
    input  logic                     d_issue_i,
    input  logic [NFWD*RIDX_W-1:0]   fwd_dst_i,
    input  logic [NFWD*XLEN-1:0]     fwd_val_i,
    input  logic [RIDX_W-1:0]        W_dstE_i,
    input  logic [XLEN-1:0]          W_valE_i,
    input  logic [RIDX_W-1:0]        W_dstM_i,
    input  logic [XLEN-1:0]          W_valM_i,
    output logic [RIDX_W-1:0]        d_srcA_o,
    output logic [RIDX_W-1:0]        d_srcB_o,
    output logic [RIDX_W-1:0]        d_dstE_o,
    output logic [RIDX_W-1:0]        d_dstM_o,
    output logic [XLEN-1:0]          d_valA_o,
    output logic [XLEN-1:0]          d_valB_o,
    output logic [NREGS-1:0]         d_busy_o
);

    localparam logic [RIDX_W-1:0] ID_NONE = '1;
    localparam logic [RIDX_W-1:0] ID_RSP  = RIDX_W'(RRSP);

    logic [RIDX_W-1:0] fwd_dst [NFWD];
    logic [XLEN-1:0]   fwd_val [NFWD];
    logic [XLEN-1:0]   rf_a_data;
    logic [XLEN-1:0]   rf_b_data;
    logic [XLEN-1:0]   fwd_a_data;
    logic [XLEN-1:0]   fwd_b_data;
    logic              fwd_a_hit;
    logic              fwd_b_hit;

    for (genvar gi = 0; gi < NFWD; gi++) begin : g_fwd_unpack
        assign fwd_dst[gi] = fwd_dst_i[gi*RIDX_W +: RIDX_W];
        assign fwd_val[gi] = fwd_val_i[gi*XLEN +: XLEN];
    end

    // Register-ID decode from icode.
    always_comb begin
        d_srcA_o = ID_NONE;
        d_srcB_o = ID_NONE;
        d_dstE_o = ID_NONE;
        d_dstM_o = ID_NONE;
        case (D_icode_i)
            IRRMOVQ: begin d_srcA_o = D_rA_i; d_dstE_o = D_rB_i; end
            IIRMOVQ: begin d_dstE_o = D_rB_i; end
            IRMMOVQ: begin d_srcA_o = D_rA_i; d_srcB_o = D_rB_i; end
            IMRMOVQ: begin d_srcB_o = D_rB_i; d_dstM_o = D_rA_i; end
            IOPQ:    begin d_srcA_o = D_rA_i; d_srcB_o = D_rB_i; d_dstE_o = D_rB_i; end
            ICALL:   begin d_srcB_o = ID_RSP; d_dstE_o = ID_RSP; end
            IRET:    begin d_srcA_o = ID_RSP; d_srcB_o = ID_RSP; d_dstE_o = ID_RSP; end
            IPUSHQ:  begin d_srcA_o = D_rA_i; d_srcB_o = ID_RSP; d_dstE_o = ID_RSP; end
            IPOPQ:   begin
                d_srcA_o = ID_RSP; d_srcB_o = ID_RSP;
                d_dstE_o = ID_RSP; d_dstM_o = D_rA_i;
            end
            default: ;
        endcase
    end

    y86_regfile #(
        .XLEN   (XLEN),
        .NREGS  (NREGS),
        .RIDX_W (RIDX_W)
    ) u_regfile (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .rd_a_id   (d_srcA_o),
        .rd_b_id   (d_srcB_o),
        .rd_a_data (rf_a_data),
        .rd_b_data (rf_b_data),
        .wr_e_id   (W_dstE_i),
        .wr_e_data (W_valE_i),
        .wr_m_id   (W_dstM_i),
        .wr_m_data (W_valM_i)
    );

    // Forwarding search; scanning from the lowest priority upward lets source 0 win.
    always_comb begin
        fwd_a_hit  = 1'b0;
        fwd_b_hit  = 1'b0;
        fwd_a_data = '0;
        fwd_b_data = '0;
        for (int k = NFWD - 1; k >= 0; k--) begin
            if (d_srcA_o != ID_NONE && fwd_dst[k] == d_srcA_o) begin
                fwd_a_hit  = 1'b1;
                fwd_a_data = fwd_val[k];
            end
            if (d_srcB_o != ID_NONE && fwd_dst[k] == d_srcB_o) begin
                fwd_b_hit  = 1'b1;
                fwd_b_data = fwd_val[k];
            end
        end
    end

    // Operand select: valP for CALL/JXX, then forwarding, then register file.
    always_comb begin
        if (D_icode_i == ICALL || D_icode_i == IJXX) begin
            d_valA_o = D_valP_i;
        end else if (d_srcA_o == ID_NONE) begin
            d_valA_o = '0;
        end else if (fwd_a_hit) begin
            d_valA_o = fwd_a_data;
        end else begin
            d_valA_o = rf_a_data;
        end

        if (d_srcB_o == ID_NONE) begin
            d_valB_o = '0;
        end else if (fwd_b_hit) begin
            d_valB_o = fwd_b_data;
        end else begin
            d_valB_o = rf_b_data;
        end
    end

    // Per-register saturating count of issued-but-not-retired writers.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_sb
        localparam logic [RIDX_W-1:0] RID = RIDX_W'(gi);
        localparam logic [SB_W-1:0]   CNT_MAX = '1;

        logic [SB_W-1:0] cnt_reg;
        logic            inc;
        logic            dec;

        assign inc = d_issue_i && (RID != ID_NONE) && (d_dstE_o == RID || d_dstM_o == RID);
        assign dec = (RID != ID_NONE) && (W_dstE_i == RID || W_dstM_i == RID);

        // Simultaneous issue and retire cancel; stick at max, never wrap below zero.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cnt_reg <= '0;
            end else if (inc && !dec && cnt_reg != CNT_MAX) begin
                cnt_reg <= cnt_reg + SB_W'(1);
            end else if (dec && !inc && cnt_reg != '0) begin
                cnt_reg <= cnt_reg - SB_W'(1);
            end
        end

        assign d_busy_o[gi] = |cnt_reg;
    end

endmodule

// File: tb/tb_decode_regfile_fwd.sv
// Self-checking bench for decode_regfile_fwd. Expected outputs are queued when
// a stimulus is driven and compared once the combinational outputs settle.
module tb_decode_regfile_fwd;

    localparam int XLEN   = 64;
    localparam int NREGS  = 15;
    localparam int RIDX_W = 4;
    localparam int NFWD   = 5;
    localparam int SB_W   = 2;

    localparam logic [3:0] I_NOP = 4'h1, I_RRMOVQ = 4'h2, I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_OPQ = 4'h6, I_JXX = 4'h7, I_CALL = 4'h8, I_POPQ = 4'hB;
    localparam logic [3:0] R_NONE = 4'hF;

    localparam int S_SRCA = 0, S_SRCB = 1, S_DSTE = 2, S_DSTM = 3;
    localparam int S_VALA = 4, S_VALB = 5, S_BUSY = 6;

    logic                   clk;
    logic                   rst;
    logic [3:0]             icode;
    logic [RIDX_W-1:0]      ra;
    logic [RIDX_W-1:0]      rb;
    logic [XLEN-1:0]        valp;
    logic                   issue;
    logic [NFWD*RIDX_W-1:0] fwd_dst;
    logic [NFWD*XLEN-1:0]   fwd_val;
    logic [RIDX_W-1:0]      w_dste;
    logic [XLEN-1:0]        w_vale;
    logic [RIDX_W-1:0]      w_dstm;
    logic [XLEN-1:0]        w_valm;
    logic [RIDX_W-1:0]      src_a;
    logic [RIDX_W-1:0]      src_b;
    logic [RIDX_W-1:0]      dst_e;
    logic [RIDX_W-1:0]      dst_m;
    logic [XLEN-1:0]        val_a;
    logic [XLEN-1:0]        val_b;
    logic [NREGS-1:0]       busy;

    int checks   = 0;
    int failures = 0;

    int              exp_sel_q[$];
    logic [XLEN-1:0] exp_val_q[$];

    decode_regfile_fwd #(
        .XLEN(XLEN), .NREGS(NREGS), .RIDX_W(RIDX_W), .NFWD(NFWD), .SB_W(SB_W)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .D_icode_i (icode),
        .D_rA_i    (ra),
        .D_rB_i    (rb),
        .D_valP_i  (valp),
        .d_issue_i (issue),
        .fwd_dst_i (fwd_dst),
        .fwd_val_i (fwd_val),
        .W_dstE_i  (w_dste),
        .W_valE_i  (w_vale),
        .W_dstM_i  (w_dstm),
        .W_valM_i  (w_valm),
        .d_srcA_o  (src_a),
        .d_srcB_o  (src_b),
        .d_dstE_o  (dst_e),
        .d_dstM_o  (dst_m),
        .d_valA_o  (val_a),
        .d_valB_o  (val_b),
        .d_busy_o  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] observe(input int sel);
        case (sel)
            S_SRCA:  return XLEN'(src_a);
            S_SRCB:  return XLEN'(src_b);
            S_DSTE:  return XLEN'(dst_e);
            S_DSTM:  return XLEN'(dst_m);
            S_VALA:  return val_a;
            S_VALB:  return val_b;
            default: return XLEN'(busy);
        endcase
    endfunction

    function automatic string sel_name(input int sel);
        case (sel)
            S_SRCA:  return "srcA";
            S_SRCB:  return "srcB";
            S_DSTE:  return "dstE";
            S_DSTM:  return "dstM";
            S_VALA:  return "valA";
            S_VALB:  return "valB";
            default: return "busy";
        endcase
    endfunction

    task automatic check_val(input string tag, input logic [XLEN-1:0] obs,
                             input logic [XLEN-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, obs);
        end
    endtask

    task automatic expect_out(input int sel, input logic [XLEN-1:0] v);
        exp_sel_q.push_back(sel);
        exp_val_q.push_back(v);
    endtask

    // Let combinational outputs settle, then compare everything queued.
    task automatic drain(input string step);
        int              sel;
        logic [XLEN-1:0] v;
        #1;
        while (exp_sel_q.size() > 0) begin
            sel = exp_sel_q.pop_front();
            v   = exp_val_q.pop_front();
            check_val({step, ".", sel_name(sel)}, observe(sel), v);
        end
    endtask

    task automatic set_fwd(input int k, input logic [RIDX_W-1:0] id, input logic [XLEN-1:0] v);
        fwd_dst[k*RIDX_W +: RIDX_W] = id;
        fwd_val[k*XLEN +: XLEN]     = v;
    endtask

    task automatic idle();
        icode  = I_NOP;
        ra     = R_NONE;
        rb     = R_NONE;
        valp   = '0;
        issue  = 1'b0;
        fwd_dst = '1;
        fwd_val = '0;
        w_dste = R_NONE;
        w_vale = '0;
        w_dstm = R_NONE;
        w_valm = '0;
    endtask

    initial begin
        logic [XLEN-1:0] wt_first;
        logic [XLEN-1:0] wt_second;
`ifdef DECODE_RF_WRITE_THROUGH_EN
        wt_first  = 64'hC0DE;
        wt_second = 64'hBEEF;
`else
        wt_first  = 64'h0;
        wt_second = 64'hC0DE;
`endif
        idle();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state, then a plain OPQ read.
        icode = I_OPQ; ra = 4'd1; rb = 4'd2;
        expect_out(S_SRCA, 1); expect_out(S_SRCB, 2);
        expect_out(S_DSTE, 2); expect_out(S_DSTM, 64'hF);
        expect_out(S_VALA, 0); expect_out(S_VALB, 0); expect_out(S_BUSY, 0);
        drain("reset_read");

        // Two writes to r3; second edge has both ports on r3 and M must win.
        @(negedge clk); idle(); w_dste = 4'd3; w_vale = 64'h55;
        @(negedge clk); idle(); w_dste = 4'd3; w_vale = 64'h77; w_dstm = 4'd3; w_valm = 64'h99;
        @(negedge clk); idle(); icode = I_RRMOVQ; ra = 4'd3; rb = 4'd8;
        expect_out(S_SRCA, 3); expect_out(S_SRCB, 64'hF); expect_out(S_DSTE, 8);
        expect_out(S_VALA, 64'h99); expect_out(S_VALB, 0);
        drain("write_m_wins");

        // Forwarding priority and RNONE handling.
        @(negedge clk); idle(); icode = I_OPQ; ra = 4'd5; rb = 4'd3;
        set_fwd(0, 4'd5, 64'hAA); set_fwd(2, 4'd5, 64'hBB);
        expect_out(S_VALA, 64'hAA); expect_out(S_VALB, 64'h99);
        drain("fwd_prio");
        set_fwd(0, R_NONE, 64'hAA);
        expect_out(S_VALA, 64'hBB);
        drain("fwd_next");
        ra = R_NONE; set_fwd(4, 4'd3, 64'hDD);
        expect_out(S_SRCA, 64'hF); expect_out(S_VALA, 0); expect_out(S_VALB, 64'hDD);
        drain("fwd_rnone");

        // CALL and JXX take valP on A.
        @(negedge clk); idle(); icode = I_CALL; valp = 64'h1234; set_fwd(1, 4'd4, 64'h100);
        expect_out(S_SRCA, 64'hF); expect_out(S_SRCB, 4); expect_out(S_DSTE, 4);
        expect_out(S_DSTM, 64'hF); expect_out(S_VALA, 64'h1234); expect_out(S_VALB, 64'h100);
        drain("call");
        icode = I_JXX; valp = 64'h2000;
        expect_out(S_VALA, 64'h2000); expect_out(S_VALB, 0); expect_out(S_DSTE, 64'hF);
        drain("jxx");

        // Scoreboard: POPQ r7 marks r4 and r7 busy.
        @(negedge clk); idle(); icode = I_POPQ; ra = 4'd7; issue = 1'b1;
        expect_out(S_DSTE, 4); expect_out(S_DSTM, 7); expect_out(S_BUSY, 0);
        drain("sb_popq");
        @(negedge clk); idle(); w_dste = 4'd4; w_dstm = 4'd7;
        icode = I_OPQ; ra = 4'd0; rb = 4'd7; issue = 1'b1;
        expect_out(S_BUSY, 15'h0090);
        drain("sb_busy47");
        @(negedge clk); idle(); w_dste = 4'd7;
        expect_out(S_BUSY, 15'h0080);
        drain("sb_r7_one");
        @(negedge clk); idle();
        expect_out(S_BUSY, 0);
        drain("sb_r7_clear");

        // dstE == dstM on the same register counts a single writer.
        icode = I_POPQ; ra = 4'd4; issue = 1'b1;
        expect_out(S_DSTE, 4); expect_out(S_DSTM, 4);
        drain("sb_same_dst");
        @(negedge clk); idle(); w_dste = 4'd4;
        expect_out(S_BUSY, 15'h0010);
        drain("sb_same_busy");
        @(negedge clk); idle();
        expect_out(S_BUSY, 0);
        drain("sb_same_clear");

        // Saturation at 3, then retire down past zero.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); idle(); icode = I_IRMOVQ; rb = 4'd1; issue = 1'b1;
            expect_out(S_BUSY, (i == 0) ? 64'h0 : 64'h2);
            drain($sformatf("sat_issue%0d", i));
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); idle(); w_dstm = 4'd1;
            if (i == 1) w_dste = 4'd1;
            expect_out(S_BUSY, (i < 3) ? 64'h2 : 64'h0);
            drain($sformatf("sat_retire%0d", i));
        end
        @(negedge clk); idle();
        expect_out(S_BUSY, 0);
        drain("sat_floor");
        icode = I_IRMOVQ; rb = 4'd1; issue = 1'b1;
        @(negedge clk); idle(); w_dstm = 4'd1;
        expect_out(S_BUSY, 64'h2);
        drain("floor_issue");
        @(negedge clk); idle();
        expect_out(S_BUSY, 0);
        drain("floor_retire");

        // Reset mid-operation drops same-cycle issue and write, clears registers.
        @(negedge clk); idle(); icode = I_IRMOVQ; rb = 4'd9; issue = 1'b1;
        w_dste = 4'd3; w_vale = 64'h42; rst = 1'b1;
        @(negedge clk); rst = 1'b0; idle(); icode = I_OPQ; ra = 4'd3; rb = 4'd9;
        expect_out(S_VALA, 0); expect_out(S_VALB, 0); expect_out(S_BUSY, 0);
        drain("mid_reset");

        // Same-cycle register-file read of a register being written.
        @(negedge clk); idle(); w_dste = 4'd6; w_vale = 64'hC0DE; icode = I_RRMOVQ; ra = 4'd6; rb = 4'd2;
        expect_out(S_VALA, wt_first);
        drain("wt_e");
        @(negedge clk); idle(); w_dste = 4'd6; w_vale = 64'h1111; w_dstm = 4'd6; w_valm = 64'hBEEF;
        icode = I_RRMOVQ; ra = 4'd6; rb = 4'd2;
        expect_out(S_VALA, wt_second);
        drain("wt_m_over_e");
        @(negedge clk); idle(); icode = I_RRMOVQ; ra = 4'd6; rb = 4'd2;
        expect_out(S_VALA, 64'hBEEF);
        drain("wt_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
